// File: rtl/midi_msg_transmitter_pkg.sv
// Shared MIDI definitions: status nibbles, message payload, FSM states and
// the status-byte to message-length lookup.
package midi_defs;

  localparam int unsigned CLKS_PER_BIT_31250 = 3200;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYS      = 4'hF;

  typedef struct packed {
    logic [BYTE_W-1:0] status;
    logic [BYTE_W-1:0] data1;
    logic [BYTE_W-1:0] data2;
  } midi_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } tx_state_t;

  // Bytes on the wire for a given status byte, before running-status removal.
  function automatic logic [CNT_W-1:0] msg_len(input logic [BYTE_W-1:0] s);
    logic [CNT_W-1:0] n;
    n = CNT_W'(0);
    case (s[7:4])
      NOTE_OFF, NOTE_ON, POLY_AT, CTRL, PITCH: n = CNT_W'(3);
      PROG, CHAN_AT:                           n = CNT_W'(2);
      SYS:                                     n = CNT_W'(1);
      default:                                 n = CNT_W'(0);
    endcase
    return n;
  endfunction

  function automatic logic is_channel(input logic [BYTE_W-1:0] s);
    return s[7] && (s[7:4] != SYS);
  endfunction

  // System-common range F0-F7, which cancels running status.
  function automatic logic is_common(input logic [BYTE_W-1:0] s);
    return (s[7:3] == 5'b11110);
  endfunction

endpackage

// File: rtl/midi_msg_transmitter_if.sv
// Message handshake between a producer and the MIDI transmitter.
interface midi_msg_transmitter_if;
  import midi_defs::*;

  logic      msg_valid;
  midi_msg_t msg;
  logic      msg_ready;

  modport master (output msg_valid, output msg, input msg_ready);
  modport slave  (input msg_valid, input msg, output msg_ready);
endinterface

// File: rtl/midi_msg_transmitter_uart_tx.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, each held
// CLKS_PER_BIT cycles; done is high during the final stop-bit cycle.
module midi_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DONE_CLK = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       STOP_BIT = 4'd9;

  logic [8:0]       shift_q;
  logic [CNT_W-1:0] baud_q;
  logic [3:0]       bit_q;

  // shift_q holds the bits still to be driven: data then the stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx      <= 1'b1;
      done    <= 1'b0;
      busy    <= 1'b0;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      done <= busy && (bit_q == STOP_BIT) && (baud_q == DONE_CLK);
      if (!busy) begin
        if (start) begin
          shift_q <= {1'b1, data};
          tx      <= 1'b0;
          busy    <= 1'b1;
          baud_q  <= '0;
          bit_q   <= '0;
        end
      end else if (baud_q == LAST_CLK) begin
        baud_q <= '0;
        if (bit_q == STOP_BIT) begin
          busy <= 1'b0;
          tx   <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx      <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_q <= baud_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/midi_msg_transmitter.sv
// MIDI message transmitter: accepts {status, data1, data2} messages and sends
// the bytes the status calls for, optionally dropping repeated channel status.
module midi_msg_transmitter
  import midi_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT   = CLKS_PER_BIT_31250,
  parameter int unsigned RUNNING_STATUS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  midi_msg_transmitter_if.slave mi,
  output logic                  midi_tx,
  output logic                  busy,
  output logic                  byte_done,
  output logic                  bad_msg
);
  tx_state_t         state_q, state_d;
  midi_msg_t         msg_q, msg_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] last_status_q, last_status_d;
  logic              msg_ready_q;
  logic              busy_d, bad_d;

  logic [BYTE_W-1:0] acc_status;
  logic [CNT_W-1:0]  acc_len;
  logic              acc_skip;

  logic              uart_start_c;
  logic [BYTE_W-1:0] uart_byte_c;
  logic              uart_done, uart_busy;

  assign mi.msg_ready = msg_ready_q;
  assign byte_done    = uart_done;

  assign acc_status = mi.msg.status;
  assign acc_len    = msg_len(acc_status);
  assign acc_skip   = (RUNNING_STATUS != 0) && is_channel(acc_status)
                      && (acc_status == last_status_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      msg_q         <= '0;
      remain_q      <= '0;
      idx_q         <= '0;
      last_status_q <= '0;
      msg_ready_q   <= 1'b1;
      busy          <= 1'b0;
      bad_msg       <= 1'b0;
    end else begin
      state_q       <= state_d;
      msg_q         <= msg_d;
      remain_q      <= remain_d;
      idx_q         <= idx_d;
      last_status_q <= last_status_d;
      msg_ready_q   <= (state_d == ST_IDLE);
      busy          <= busy_d;
      bad_msg       <= bad_d;
    end
  end

  // idx_q walks status/data1/data2; a suppressed status starts it at data1.
  always_comb begin
    state_d       = state_q;
    msg_d         = msg_q;
    remain_d      = remain_q;
    idx_d         = idx_q;
    last_status_d = last_status_q;
    bad_d         = 1'b0;
    uart_start_c  = 1'b0;
    uart_byte_c   = msg_q.status;
    unique case (state_q)
      ST_IDLE: begin
        if (mi.msg_valid && msg_ready_q) begin
          msg_d    = mi.msg;
          remain_d = acc_len - CNT_W'(acc_skip);
          idx_d    = CNT_W'(acc_skip);
          bad_d    = ~acc_status[7];
          state_d  = ST_LOAD;
          if (is_channel(acc_status)) begin
            last_status_d = acc_status;
          end else if (is_common(acc_status)) begin
            last_status_d = '0;
          end
        end
      end
      ST_LOAD: begin
        if (remain_q == '0) begin
          state_d = ST_IDLE;
        end else if (!uart_busy) begin
          uart_start_c = 1'b1;
          state_d      = ST_SEND;
          case (idx_q)
            CNT_W'(0): uart_byte_c = msg_q.status;
            CNT_W'(1): uart_byte_c = msg_q.data1;
            default:   uart_byte_c = msg_q.data2;
          endcase
        end
      end
      ST_SEND: begin
        if (uart_done) begin
          remain_d = remain_q - CNT_W'(1);
          idx_d    = idx_q + CNT_W'(1);
          state_d  = (remain_q == CNT_W'(1)) ? ST_IDLE : ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  midi_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (uart_start_c),
    .data  (uart_byte_c),
    .tx    (midi_tx),
    .done  (uart_done),
    .busy  (uart_busy)
  );
endmodule

// File: tb/tb_midi_msg_transmitter.sv
// Two transmitters (running status off/on) fed the same messages; serial
// lines are decoded and compared against a message-level byte model.
module tb_midi_msg_transmitter;
  import midi_defs::*;

  localparam int unsigned C      = 4;
  localparam int          BYTE_T = 10 * C + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [23:0] m0 = '0, m1 = '0;
  logic tx0, busy0, bd0, bad0, rdy0;
  logic tx1, busy1, bd1, bad1, rdy1;

  int checks = 0, errors = 0;
  int nbd0 = 0, nbd1 = 0, nbad0 = 0, nbad1 = 0, ebad0 = 0, ebad1 = 0;
  int nfr[2];
  int last_n = 0;
  logic [7:0] ls0 = '0, ls1 = '0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  midi_msg_transmitter_if if0 ();
  midi_msg_transmitter_if if1 ();
  assign if0.msg_valid = v0;
  assign if0.msg       = midi_msg_t'(m0);
  assign if1.msg_valid = v1;
  assign if1.msg       = midi_msg_t'(m1);
  assign rdy0 = if0.msg_ready;
  assign rdy1 = if1.msg_ready;

  midi_msg_transmitter #(.CLKS_PER_BIT(C), .RUNNING_STATUS(0)) dut0 (
    .clk(clk), .reset(reset), .mi(if0.slave),
    .midi_tx(tx0), .busy(busy0), .byte_done(bd0), .bad_msg(bad0));
  midi_msg_transmitter #(.CLKS_PER_BIT(C), .RUNNING_STATUS(1)) dut1 (
    .clk(clk), .reset(reset), .mi(if1.slave),
    .midi_tx(tx1), .busy(busy1), .byte_done(bd1), .bad_msg(bad1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic txl(input int w);
    return (w != 0) ? tx1 : tx0;
  endfunction

  function automatic logic bdl(input int w);
    return (w != 0) ? bd1 : bd0;
  endfunction

  // Message-level model: which bytes go on each line for message x.
  task automatic expect_msg(input logic [23:0] x);
    for (int w = 0; w < 2; w++) begin
      logic [7:0] s, ls;
      logic [7:0] seq[$];
      seq.delete();
      s  = x[23:16];
      ls = (w != 0) ? ls1 : ls0;
      if (!s[7]) begin
        if (w != 0) ebad1++; else ebad0++;
      end else if (s >= 8'hF0) begin
        seq.push_back(s);
        if (s < 8'hF8) ls = 8'h00;
      end else begin
        if (!(w == 1 && s == ls)) seq.push_back(s);
        seq.push_back(x[15:8]);
        if (s[7:4] != 4'hC && s[7:4] != 4'hD) seq.push_back(x[7:0]);
        ls = s;
      end
      foreach (seq[i]) begin
        if (w != 0) q1.push_back(seq[i]); else q0.push_back(seq[i]);
      end
      if (w != 0) ls1 = ls; else begin ls0 = ls; last_n = seq.size(); end
    end
  endtask

  // Decode one serial line; every bit must hold for exactly C samples.
  task automatic mon(input int w);
    logic [9:0] fr;
    logic [7:0] e;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (!reset && txl(w) == 1'b0) begin
        ok = 1; ab = 0; fr = '0;
        for (int b = 0; b < 10 && !ab; b++) begin
          for (int c = 0; c < int'(C) && !ab; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (reset) ab = 1;
            else begin
              if (c == 0) fr[b] = txl(w);
              else if (txl(w) != fr[b]) ok = 0;
              if (bdl(w) != (b == 9 && c == int'(C) - 1)) ok = 0;
            end
          end
        end
        if (!ab) begin
          checks++;
          nfr[w]++;
          if ((w != 0 && q1.size() == 0) || (w == 0 && q0.size() == 0)) begin
            errors++;
            $display("FAIL frame dut%0d: got byte %02h, expected no byte", w, fr[8:1]);
          end else begin
            e = (w != 0) ? q1.pop_front() : q0.pop_front();
            if (!ok || fr[0] || !fr[9] || fr[8:1] != e) begin
              errors++;
              $display("FAIL frame dut%0d: got %02h (framing ok=%0d) expected %02h",
                       w, fr[8:1], ok, e);
            end
          end
          @(negedge clk);
          if (!reset) chk($sformatf("gap_dut%0d", w), int'(txl(w)), 1);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bd0)  nbd0++;
        if (bd1)  nbd1++;
        if (bad0) nbad0++;
        if (bad1) nbad1++;
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_tx0"},   int'(tx0),   1);
    chk({tag, "_tx1"},   int'(tx1),   1);
    chk({tag, "_rdy0"},  int'(rdy0),  1);
    chk({tag, "_rdy1"},  int'(rdy1),  1);
    chk({tag, "_busy0"}, int'(busy0), 0);
    chk({tag, "_busy1"}, int'(busy1), 0);
    chk({tag, "_bd0"},   int'(bd0),   0);
    chk({tag, "_bad0"},  int'(bad0),  0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(rdy0 && rdy1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!(rdy0 && rdy1)) chk("wait_idle_timeout", 0, 1);
  endtask

  // Queue a message to both DUTs; each input drops once that DUT accepts.
  task automatic send(input logic [23:0] x);
    bit p0 = 0, p1 = 0;
    int t = 0;
    expect_msg(x);
    m0 = x; m1 = x; v0 = 1'b1; v1 = 1'b1;
    while ((v0 || v1) && t < 3000) begin
      if (v0 && rdy0) p0 = 1;
      if (v1 && rdy1) p1 = 1;
      @(negedge clk);
      t++;
      if (p0 && v0) begin v0 = 1'b0; m0 = 24'($urandom); end
      if (p1 && v1) begin v1 = 1'b0; m1 = 24'($urandom); end
    end
    if (v0 || v1) begin
      chk("send_timeout", 0, 1);
      v0 = 1'b0; v1 = 1'b0;
    end
  endtask

  // Cycle-accurate view of dut0, counting from the acceptance cycle as 0.
  task automatic timed(input logic [23:0] x, input string tag);
    int first_start = -1, bad_cyc = -1, last_busy = -1, rdy_cyc = -1;
    int nbd = 0, last_bd = -1, n;
    wait_idle();
    expect_msg(x);
    n = last_n;
    m0 = x; m1 = x; v0 = 1'b1; v1 = 1'b1;
    for (int c = 1; c < 2000 && rdy_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        v0 = 1'b0; v1 = 1'b0;
        m0 = 24'($urandom); m1 = 24'($urandom);
      end
      if (!tx0 && first_start < 0) first_start = c;
      if (bad0)  bad_cyc = c;
      if (busy0) last_busy = c;
      if (bd0) begin nbd++; last_bd = c; end
      if (rdy0) rdy_cyc = c;
    end
    if (n == 0) begin
      chk({tag, "_bad_cycle"},   bad_cyc,     1);
      chk({tag, "_no_start"},    first_start, -1);
      chk({tag, "_ready_cycle"}, rdy_cyc,     2);
      chk({tag, "_byte_dones"},  nbd,         0);
    end else begin
      chk({tag, "_first_start"}, first_start,   2);
      chk({tag, "_byte_dones"},  nbd,           n);
      chk({tag, "_last_done"},   last_bd,       n * BYTE_T);
      chk({tag, "_ready_cycle"}, rdy_cyc,       n * BYTE_T + 1);
      chk({tag, "_busy_span"},   last_busy + 1, n * BYTE_T + 1);
      chk({tag, "_no_bad"},      bad_cyc,       -1);
    end
  endtask

  initial begin
    logic [7:0] s;
    int b0;
    nfr[0] = 0; nfr[1] = 0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    timed(24'h903C64, "note_on");
    timed(24'h3C6400, "bad");
    timed(24'hC50711, "prog");

    send(24'h903C64); send(24'h904050); send(24'h804000);
    send(24'hC507AA); send(24'hD220BB);
    send(24'h903C64); send(24'hF80000); send(24'h903C00);
    send(24'hF20000); send(24'h903C00);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: s = 8'h90;
        1: s = 8'h80;
        2: s = 8'hC5;
        3: s = 8'hD2;
        4: s = 8'hF8;
        5: s = 8'hF2;
        6: s = 8'h3C;
        7: s = 8'hE1;
        default: s = 8'($urandom);
      endcase
      send({s, 16'($urandom)});
    end

    wait_idle();
    send(24'h903C64);
    b0 = nbd0;
    for (int t = 0; t < 500 && nbd0 == b0; t++) @(negedge clk);
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_tx0",  int'(tx0),  1);
    chk("midreset_rdy0", int'(rdy0), 1);
    chk("midreset_tx1",  int'(tx1),  1);
    chk("midreset_rdy1", int'(rdy1), 1);
    q0.delete(); q1.delete();
    ls0 = 8'h00; ls1 = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("after_midreset");
    timed(24'h903C64, "resend");

    for (int t = 0; t < 5000 && (q0.size() != 0 || q1.size() != 0 || !rdy0 || !rdy1); t++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("q0_left",        q0.size(), 0);
    chk("q1_left",        q1.size(), 0);
    chk("byte_done0_cnt", nbd0,      nfr[0]);
    chk("byte_done1_cnt", nbd1,      nfr[1]);
    chk("bad0_cnt",       nbad0,     ebad0);
    chk("bad1_cnt",       nbad1,     ebad1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/midi_msg_transmitter.md
Name: midi_msg_transmitter

Overview:
- Transmit-side counterpart of the MIDI capture path: accepts one 24-bit MIDI message per handshake and serializes it onto a 31250-baud MIDI/UART line.
- Message layout is the same as the capture side: status in msg[23:16], data1 in msg[15:8], data2 in msg[7:0].
- Message length comes from the status byte; optional running-status compression drops repeated status bytes.
- Used to echo/forward note events and to drive the loopback test of the capture path.

Parameters:
- CLKS_PER_BIT, 3200, clk cycles per serial bit (100 MHz / 31250 baud); must be >= 2.
- RUNNING_STATUS, 1, 1 = omit a channel status byte equal to the last one sent; 0 = always send status.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- msg_valid  input  1  msg holds a message to send
- msg  input  24  {status, data1, data2}
- msg_ready  output  1  high only in IDLE; a message is accepted on a cycle with msg_valid && msg_ready
- midi_tx  output  1  serial line; idle high
- busy  output  1  high from acceptance until the last stop bit completes
- byte_done  output  1  one-cycle pulse at the end of each byte's stop bit
- bad_msg  output  1  one-cycle pulse when an accepted message has status[7]==0

Behaviour:
- Reset (async) values: midi_tx=1, msg_ready=1, busy=0, byte_done=0, bad_msg=0, last_status=0, FSM=IDLE, counters=0.
- Byte count from the status byte s:
  - 8x, 9x, Ax, Bx, Ex: 3 bytes.
  - Cx, Dx: 2 bytes.
  - F0-F7: 1 byte (status only); sets last_status=0.
  - F8-FF (realtime): 1 byte; last_status unchanged.
  - s[7]==0: 0 bytes; bad_msg pulses the cycle after acceptance; return to IDLE with no line activity.
- Running status: when RUNNING_STATUS=1, s is 80-EF, and s==last_status, skip the status byte, so 1 or 2 bytes are sent. Every channel message sets last_status=s.
- FSM:
  - IDLE: on accept, latch msg, byte count and skip flag; go to LOAD.
  - LOAD: select the next byte (status, data1, data2 in that order); go to SEND.
  - SEND: the sub-module shifts 10 bits. On its done pulse, decrement the remaining count; go to LOAD if nonzero, else IDLE.
- Serial framing:
  - Start bit 0, then d[0]..d[7] LSB first, then stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - midi_tx falls to start bit 1 cycle after LOAD.
  - Byte period is 10*CLKS_PER_BIT; consecutive bytes of one message are separated by exactly 1 idle-high cycle (LOAD).
- Latency: accept at cycle 0, first start bit at cycle 2, msg_ready high again the cycle after the last byte_done.
- msg is sampled only at acceptance; later changes are ignored. msg_valid asserted while busy is held off; no message is lost or duplicated.
- Data bytes are sent exactly as given, including bit 7; no range check.
- Reset mid-byte: line returns high immediately; the partial byte is abandoned; running status is cleared.

Decomposition:
- Shared package (midi_defs):
  - status-nibble constants: NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CTRL=B, PROG=C, CHAN_AT=D, PITCH=E, SYS=F
  - the length-lookup function
  - the 31250-baud CLKS_PER_BIT constant
- One sub-module, midi_uart_tx (load/start, byte in, tx, done, busy), owns the baud counter and the 10-bit shift; this block holds the FSM and running-status state.

Test Plan:
- CLKS_PER_BIT=4, RUNNING_STATUS=0, msg=90_3C_64.
  -> line carries bytes 90, 3C, 64, each 40 cycles, with 1 idle cycle between bytes; 3 byte_done pulses; busy spans 2+40*3+2 cycles; msg_ready low throughout.
- RUNNING_STATUS=1: send 90_3C_64 then 90_40_50.
  -> second message emits only 40, 50 (80 cycles).
  Then send 80_40_00.
  -> 3 bytes including 80.
- C5_07_xx, then D2_20_xx.
  -> 2 bytes each (C5 07, then D2 20); data2 never sent.
- Running status set by 90_..., then F8_00_00, then 90_3C_00.
  -> F8 sent alone; the following 90 is still suppressed.
  Repeat with F2 in place of F8.
  -> 90 is re-sent.
- msg=3C_64_00.
  -> bad_msg pulse on cycle 1; midi_tx stays 1; msg_ready high on cycle 2.
- Assert reset in the middle of the 2nd byte.
  -> midi_tx=1 and msg_ready=1 the same cycle.
  Resend 90_3C_64 with RUNNING_STATUS=1.
  -> full 3 bytes, including 90.
